// File: rtl/vot_n_mon_if.sv
// Handshake and result bundle for the N-channel majority voter.
// The master drives samples and clears; the slave returns the vote and health state.
// No backpressure: every in_valid sample is consumed.
interface vot_n_mon_if #(
    parameter int N = 3,
    parameter int W = 8
);
    localparam int AW = $clog2(N + 1);

    logic            in_valid;
    logic [N*W-1:0]  din;
    logic [N-1:0]    clr_fault;
    logic            out_valid;
    logic [W-1:0]    vot;
    logic [N-1:0]    mismatch;
    logic            tie;
    logic            no_quorum;
    logic [N-1:0]    fault;
    logic [AW-1:0]   n_active;

    modport master (
        output in_valid, din, clr_fault,
        input  out_valid, vot, mismatch, tie, no_quorum, fault, n_active
    );

    modport slave (
        input  in_valid, din, clr_fault,
        output out_valid, vot, mismatch, tie, no_quorum, fault, n_active
    );
endinterface

// File: rtl/vot_n_mon.sv
// Bitwise majority voter over healthy channels with per-channel fault latching.
// Latency: one clock from in_valid to out_valid.
// No backpressure: a sample is accepted on every cycle in_valid is high.
module vot_n_mon #(
    parameter int N         = 3,
    parameter int W         = 8,
    parameter int FAULT_LIM = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    vot_n_mon_if.slave   bus
);
    localparam int CW = $clog2(FAULT_LIM + 1);
    localparam int AW = $clog2(N + 1);
    localparam logic [CW-1:0] LIM   = CW'(FAULT_LIM);
    localparam logic [AW-1:0] N_ALL = AW'(N);

    logic                   out_valid_q, out_valid_d;
    logic [W-1:0]           vot_q, vot_d;
    logic [N-1:0]           mismatch_q, mismatch_d;
    logic                   tie_q, tie_d;
    logic                   no_quorum_q, no_quorum_d;
    logic [N-1:0]           fault_q, fault_d;
    logic [N-1:0][CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]          n_active_q, n_active_d;

    logic [N-1:0]           active;
    logic [AW-1:0]          a_cnt;
    logic [AW-1:0]          ones;
    logic [W-1:0]           new_vot;
    logic [W-1:0]           bit_tie;
    logic [N-1:0]           mm_now;
    logic [AW-1:0]          fault_pop;

    // Membership uses only the fault state from before this edge.
    always_comb begin
        active = ~fault_q;
        a_cnt  = '0;
        for (int i = 0; i < N; i++) begin
            a_cnt = a_cnt + AW'(active[i]);
        end
    end

    always_comb begin
        ones    = '0;
        new_vot = '0;
        bit_tie = '0;
        for (int b = 0; b < W; b++) begin
            ones = '0;
            for (int i = 0; i < N; i++) begin
                ones = ones + AW'(active[i] & bus.din[i*W + b]);
            end
            new_vot[b] = ({ones, 1'b0} >  {1'b0, a_cnt});
            bit_tie[b] = ({ones, 1'b0} == {1'b0, a_cnt});
        end
    end

    always_comb begin
        out_valid_d = bus.in_valid;
        vot_d       = vot_q;
        mismatch_d  = mismatch_q;
        tie_d       = tie_q;
        no_quorum_d = no_quorum_q;
        fault_d     = fault_q;
        cnt_d       = cnt_q;
        mm_now      = '0;

        if (bus.in_valid) begin
            if (a_cnt == '0) begin
                no_quorum_d = 1'b1;
                mismatch_d  = '0;
                tie_d       = 1'b0;
            end else begin
                vot_d       = new_vot;
                tie_d       = |bit_tie;
                no_quorum_d = 1'b0;
                for (int i = 0; i < N; i++) begin
                    mm_now[i] = active[i] && (bus.din[i*W +: W] != new_vot);
                end
                mismatch_d = mm_now;
                for (int i = 0; i < N; i++) begin
                    if (active[i]) begin
                        if (mm_now[i]) begin
                            if (cnt_q[i] != LIM) begin
                                cnt_d[i] = cnt_q[i] + 1'b1;
                            end
                            fault_d[i] = (cnt_d[i] == LIM);
                        end else begin
                            cnt_d[i] = '0;
                        end
                    end
                end
            end
        end

        // A clear wins over any increment or fault set on the same edge.
        for (int i = 0; i < N; i++) begin
            if (bus.clr_fault[i]) begin
                cnt_d[i]   = '0;
                fault_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        fault_pop = '0;
        for (int i = 0; i < N; i++) begin
            fault_pop = fault_pop + AW'(fault_d[i]);
        end
        n_active_d = N_ALL - fault_pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            vot_q       <= '0;
            mismatch_q  <= '0;
            tie_q       <= 1'b0;
            no_quorum_q <= 1'b0;
            fault_q     <= '0;
            cnt_q       <= '0;
            n_active_q  <= N_ALL;
        end else begin
            out_valid_q <= out_valid_d;
            vot_q       <= vot_d;
            mismatch_q  <= mismatch_d;
            tie_q       <= tie_d;
            no_quorum_q <= no_quorum_d;
            fault_q     <= fault_d;
            cnt_q       <= cnt_d;
            n_active_q  <= n_active_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.vot       = vot_q;
    assign bus.mismatch  = mismatch_q;
    assign bus.tie       = tie_q;
    assign bus.no_quorum = no_quorum_q;
    assign bus.fault     = fault_q;
    assign bus.n_active  = n_active_q;
endmodule

// File: tb/tb_vot_n_mon.sv
// Directed bench for vot_n_mon (N=3, W=8, FAULT_LIM=4).
// Snapshot layout: {out_valid, vot, mismatch, tie, no_quorum, fault, n_active}.
module tb_vot_n_mon;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    vot_n_mon_if #(.N(3), .W(8)) bus ();

    vot_n_mon #(.N(3), .W(8), .FAULT_LIM(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [18:0] snap();
        return {bus.out_valid, bus.vot, bus.mismatch, bus.tie, bus.no_quorum, bus.fault, bus.n_active};
    endfunction

    task automatic send(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                        input logic [2:0] clr);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.din       = {d2, d1, d0};
        bus.clr_fault = clr;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.clr_fault = 3'b000;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [18:0] obs;
        logic [18:0] exp;
        exp = {1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 3'b000, 2'd3};
        obs = snap();
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL reset_async got %h want %h", obs, exp); end
        @(posedge clk); #1;
        obs = snap();
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL reset_held got %h want %h", obs, exp); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_agree();
        logic [18:0] obs;
        logic [18:0] exp;
        send(8'h5A, 8'h5A, 8'h5A, 3'b000);
        obs = snap(); exp = {1'b1, 8'h5A, 3'b000, 1'b0, 1'b0, 3'b000, 2'd3};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL agree got %h want %h", obs, exp); end
        idle();
        obs = snap(); exp = {1'b0, 8'h5A, 3'b000, 1'b0, 1'b0, 3'b000, 2'd3};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL agree_idle_hold got %h want %h", obs, exp); end
    endtask

    task automatic test_upset();
        logic [18:0] obs;
        logic [18:0] exp;
        send(8'h0F, 8'hFF, 8'h0F, 3'b000);
        obs = snap(); exp = {1'b1, 8'h0F, 3'b010, 1'b0, 1'b0, 3'b000, 2'd3};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL upset got %h want %h", obs, exp); end
        send(8'h0F, 8'h0F, 8'h0F, 3'b000);
        obs = snap(); exp = {1'b1, 8'h0F, 3'b000, 1'b0, 1'b0, 3'b000, 2'd3};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL upset_match got %h want %h", obs, exp); end
        // Three more mismatches only fault if the earlier one was not forgotten.
        for (int k = 1; k <= 3; k++) begin
            send(8'h0F, 8'hFF, 8'h0F, 3'b000);
            obs = snap(); exp = {1'b1, 8'h0F, 3'b010, 1'b0, 1'b0, 3'b000, 2'd3};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL upset_recount%0d got %h want %h", k, obs, exp); end
        end
        send(8'h0F, 8'h0F, 8'h0F, 3'b000);
        obs = snap(); exp = {1'b1, 8'h0F, 3'b000, 1'b0, 1'b0, 3'b000, 2'd3};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL upset_rematch got %h want %h", obs, exp); end
    endtask

    task automatic test_fault_latch();
        logic [18:0] obs;
        logic [18:0] exp;
        for (int k = 1; k <= 4; k++) begin
            send(8'h55, 8'h55, 8'hAA, 3'b000);
            obs = snap();
            exp = {1'b1, 8'h55, 3'b100, 1'b0, 1'b0,
                   (k == 4) ? 3'b100 : 3'b000, (k == 4) ? 2'd2 : 2'd3};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL latch%0d got %h want %h", k, obs, exp); end
        end
        send(8'h55, 8'h55, 8'h00, 3'b000);
        obs = snap(); exp = {1'b1, 8'h55, 3'b000, 1'b0, 1'b0, 3'b100, 2'd2};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL latch_excluded got %h want %h", obs, exp); end
    endtask

    task automatic test_tie();
        logic [18:0] obs;
        logic [18:0] exp;
        send(8'hF0, 8'h0F, 8'h00, 3'b000);
        obs = snap(); exp = {1'b1, 8'h00, 3'b011, 1'b1, 1'b0, 3'b100, 2'd2};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL tie got %h want %h", obs, exp); end
        send(8'h55, 8'h55, 8'h00, 3'b000);
        obs = snap(); exp = {1'b1, 8'h55, 3'b000, 1'b0, 1'b0, 3'b100, 2'd2};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL tie_cleared got %h want %h", obs, exp); end
    endtask

    task automatic test_clear_priority();
        logic [18:0] obs;
        logic [18:0] exp;
        // With two voters a tie votes 0, so only the all-ones channel disagrees.
        for (int k = 1; k <= 3; k++) begin
            send(8'h00, 8'hFF, 8'h77, 3'b000);
            obs = snap(); exp = {1'b1, 8'h00, 3'b010, 1'b1, 1'b0, 3'b100, 2'd2};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL clrpri_pre%0d got %h want %h", k, obs, exp); end
        end
        send(8'h00, 8'hFF, 8'h77, 3'b100);
        obs = snap(); exp = {1'b1, 8'h00, 3'b010, 1'b1, 1'b0, 3'b010, 2'd2};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL clrpri_edge got %h want %h", obs, exp); end
        send(8'h3C, 8'h00, 8'h3C, 3'b000);
        obs = snap(); exp = {1'b1, 8'h3C, 3'b000, 1'b0, 1'b0, 3'b010, 2'd2};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL clrpri_rejoin got %h want %h", obs, exp); end
    endtask

    task automatic test_async_reset();
        logic [18:0] obs;
        logic [18:0] exp;
        for (int k = 1; k <= 4; k++) begin
            send(8'h00, 8'h77, 8'hFF, 3'b000);
            obs = snap();
            exp = {1'b1, 8'h00, 3'b100, 1'b1, 1'b0,
                   (k == 4) ? 3'b110 : 3'b010, (k == 4) ? 2'd1 : 2'd2};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL arst_pre%0d got %h want %h", k, obs, exp); end
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        obs = snap(); exp = {1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 3'b000, 2'd3};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL arst_immediate got %h want %h", obs, exp); end
        #2;
        rst_n = 1'b1;
        send(8'h00, 8'hFF, 8'hFF, 3'b000);
        obs = snap(); exp = {1'b1, 8'hFF, 3'b001, 1'b0, 1'b0, 3'b000, 2'd3};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL arst_first_vote got %h want %h", obs, exp); end
    endtask

    task automatic test_no_quorum();
        logic [18:0] obs;
        logic [18:0] exp;
        for (int k = 1; k <= 4; k++) begin
            send(8'h55, 8'h55, 8'hAA, 3'b000);
        end
        obs = snap(); exp = {1'b1, 8'h55, 3'b100, 1'b0, 1'b0, 3'b100, 2'd2};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL nq_ch2_fault got %h want %h", obs, exp); end
        for (int k = 1; k <= 4; k++) begin
            send(8'hF3, 8'h0F, 8'h00, 3'b000);
            obs = snap();
            exp = {1'b1, 8'h03, 3'b011, 1'b1, 1'b0,
                   (k == 4) ? 3'b111 : 3'b100, (k == 4) ? 2'd0 : 2'd2};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL nq_tie%0d got %h want %h", k, obs, exp); end
        end
        send(8'hFF, 8'hFF, 8'hFF, 3'b000);
        obs = snap(); exp = {1'b1, 8'h03, 3'b000, 1'b0, 1'b1, 3'b111, 2'd0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL nq_sample got %h want %h", obs, exp); end
        idle();
        obs = snap(); exp = {1'b0, 8'h03, 3'b000, 1'b0, 1'b1, 3'b111, 2'd0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL nq_idle got %h want %h", obs, exp); end
        send(8'hFF, 8'hFF, 8'hFF, 3'b111);
        obs = snap(); exp = {1'b1, 8'h03, 3'b000, 1'b0, 1'b1, 3'b000, 2'd3};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL nq_clear_all got %h want %h", obs, exp); end
        send(8'h11, 8'h11, 8'h22, 3'b000);
        obs = snap(); exp = {1'b1, 8'h11, 3'b100, 1'b0, 1'b0, 3'b000, 2'd3};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL nq_rejoin got %h want %h", obs, exp); end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        bus.in_valid  = 1'b0;
        bus.din       = '0;
        bus.clr_fault = '0;
        rst_n         = 1'b1;
        #2;
        rst_n = 1'b0;
        #2;
        test_reset();
        test_agree();
        test_upset();
        test_fault_latch();
        test_tie();
        test_clear_priority();
        test_async_reset();
        test_no_quorum();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vot_n_mon.md
Name: vot_n_mon

Overview:
Registered N-channel, W-bit bitwise majority voter with per-channel health monitoring, for redundant (TMR/NMR) datapaths.
- Each valid sample is voted bit-by-bit over the channels currently marked healthy.
- A channel that disagrees with the voted result on FAULT_LIM consecutive valid samples is latched faulty and excluded from later votes.
- A faulty channel returns to the vote only after an explicit clear.

Parameters:
N, 3, number of voting channels (N >= 3).
W, 8, bit width of each channel word.
FAULT_LIM, 4, consecutive-mismatch count that declares a channel faulty (1..255).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous reset, active low.
in_valid  input  1  din holds a sample to vote this cycle.
din  input  N*W  channel words; channel i occupies bits [i*W +: W].
clr_fault  input  N  per-channel clear of fault flag and mismatch counter.
out_valid  output  1  vot/mismatch/tie/no_quorum updated this cycle.
vot  output  W  voted word.
mismatch  output  N  channel i disagreed with vot on the last voted sample.
tie  output  1  at least one bit of the last vote had equal ones/zeros count.
no_quorum  output  1  last sample arrived with zero healthy channels.
fault  output  N  latched per-channel fault flags.
n_active  output  clog2(N+1)  number of channels with fault = 0.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - out_valid, vot, mismatch, tie, no_quorum, fault all go to 0.
  - All mismatch counters go to 0.
  - n_active goes to N.
- Latency: exactly one clock. A sample with in_valid at edge k appears on the outputs with out_valid = 1 after edge k.
- out_valid is 1 for exactly one cycle per accepted sample. Back-to-back in_valid produces back-to-back out_valid.
- When in_valid = 0:
  - out_valid = 0.
  - vot, mismatch, tie and no_quorum hold their values.
  - Counters and faults change only through clr_fault.
- Active set: channel i is active iff fault[i] = 0 at the sampling edge. Only fault state from before the edge is used.
- Vote, for each bit b, with A = number of active channels and ones = number of active channels with din bit b = 1:
  - vot[b] = 1 iff 2*ones > A (strict majority).
  - If 2*ones == A, vot[b] = 0 and tie = 1.
  - Ties are only possible when A is even.
- A = 0 case:
  - vot holds its previous value.
  - no_quorum = 1, mismatch = 0, tie = 0, out_valid = 1.
  - Counters are unchanged.
- Mismatch: mismatch[i] = active(i) AND (din word i != new vot). Faulty channels always report mismatch = 0.
- Per-channel state machine (one per channel):
  - OK: counter = 0, fault = 0.
  - SUSPECT: 0 < counter < FAULT_LIM, fault = 0.
  - FAULTY: fault = 1; counter frozen at FAULT_LIM.
  - OK/SUSPECT, on a valid sample with mismatch: counter + 1. Reaching FAULT_LIM moves to FAULTY, with fault = 1 on the same edge as the out_valid that reports the mismatch.
  - OK/SUSPECT, on a valid sample with a match: counter returns to 0 (OK).
  - FAULTY: stays FAULTY until clr_fault[i].
  - clr_fault[i] = 1 at an edge: counter = 0, fault[i] = 0, from any state. Clear has priority over a simultaneous mismatch increment or fault set on that channel.
  - The cleared channel takes part in votes from the next sample onward.
- Counter width: clog2(FAULT_LIM+1). Counters saturate and never wrap.
- n_active is registered and equals N minus popcount(fault) at all times, including the edge where fault changes.
- All channels may become faulty; the block then operates in no_quorum mode until a clear arrives.

Test Plan:
1. Agreement (N=3, W=8): din = {0x5A, 0x5A, 0x5A}, in_valid one cycle -> next cycle out_valid = 1, vot = 0x5A, mismatch = 000, fault = 000, n_active = 3.
2. Single-bit upset: din = {0x0F, 0xFF, 0x0F} -> vot = 0x0F, mismatch = 010. Then one matching sample -> channel 1 counter back to 0, fault stays 000.
3. Fault latch (FAULT_LIM = 4): channel 2 = 0xAA, channels 0/1 = 0x55, for 4 consecutive valid samples -> fault[2] = 1 on the 4th out_valid, n_active = 2. A 5th sample with din2 = 0x00 -> mismatch = 000, vot = 0x55.
4. Tie with 2 active: after test 3, din0 = 0xF0, din1 = 0x0F -> vot = 0x00, tie = 1, mismatch = 011.
5. Clear priority: assert clr_fault[2] on the same edge as a 4th mismatch of channel 1 (channel 1 already at count 3) -> fault = 010 (channel 1 faults, channel 2 cleared), n_active = 2. The next sample votes channels 0 and 2.
6. Async reset mid-run: pull rst_n low between clock edges while fault = 110 -> outputs and fault go to 0 immediately, without waiting for an edge. After release, the first sample votes all 3 channels.
